regfile_port_decoder: RTL and testbench

- Parametrised, pipelined address decoder for the processor register file.
- Each cycle it decodes NUM_READ read addresses and one write address into registered one-hot select vectors of 2**ADDR_W bits.
- Register 0 is write-protected.
- Flags read/write same-register collisions so the register file read path can bypass the write data.
- Sits between decode-stage address fields and the register file enables; replaces the fixed 5-to-32 combinational read decoder.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/onehot_decoder.sv | 33 +++
 rtl/regfile_port_decoder.sv | 118 +++++++++++
 tb/tb_regfile_port_decoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register-file port decode path.
// Latency: none (package only).
// Backpressure: none (package only).
package regfile_pkg;

  // Default register-file geometry: 32 registers addressed by 5 bits.
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // Register 0 is the hardwired-zero register.
  localparam int R0_ADDR    = 0;

  // Width of a one-hot select vector for an address of addr_w bits.
  function automatic int onehot_width(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational binary-to-one-hot decoder with enable (all-zero when disabled).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows inputs.
//
// Ports:
//   en_i   - enable; when low sel_o is all-zero
//   addr_i - binary address, ADDR_W bits
//   sel_o  - one-hot select, 2**ADDR_W bits
module onehot_decoder
  import regfile_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                             en_i,
  input  logic [ADDR_W-1:0]                addr_i,
  output logic [onehot_width(ADDR_W)-1:0]  sel_o
);

  localparam int N = onehot_width(ADDR_W);

  // Shift-stage ladder: the enable bit enters at position 0 and each address
  // bit k conditionally moves it up by 2**k, so depth grows with log2(N).
  logic [N-1:0] stage [ADDR_W+1];

  assign stage[0] = N'(en_i);

  for (genvar k = 0; k < ADDR_W; k++) begin : g_stage
    assign stage[k+1] = addr_i[k] ? (stage[k] << (1 << k)) : stage[k];
  end

  assign sel_o = stage[ADDR_W];

endmodule

// File: rtl/regfile_port_decoder.sv
// Pipelined register-file address decoder: NUM_READ read + 1 write one-hot selects, bypass flags.
// Latency: 1 cycle from an accepted set (in_valid & ~stall) to registered outputs.
// Backpressure: stall holds every output register and leaves the input set unconsumed; in_ready = ~stall.
//
// Ports:
//   clock, reset   - rising-edge clock, synchronous active-low reset
//   in_valid       - input address set is valid
//   stall          - freeze outputs, do not consume input
//   rd_addr        - packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//   wr_addr, wr_en - write address and request
//   in_ready       - ~stall
//   out_valid      - outputs hold a decoded set
//   rd_sel         - one-hot read selects, port p at [p*NREG +: NREG]
//   wr_sel         - one-hot write select or zero
//   bypass         - port p reads the register written in the same set
//   r0_write_drop  - the captured set carried a suppressed write to r0
module regfile_port_decoder
  import regfile_pkg::*;
#(
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int NUM_READ   = 2,
  parameter bit PROTECT_R0 = 1'b1
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       in_valid,
  input  logic                                       stall,
  input  logic [NUM_READ*ADDR_W-1:0]                 rd_addr,
  input  logic [ADDR_W-1:0]                          wr_addr,
  input  logic                                       wr_en,
  output logic                                       in_ready,
  output logic                                       out_valid,
  output logic [NUM_READ*onehot_width(ADDR_W)-1:0]   rd_sel,
  output logic [onehot_width(ADDR_W)-1:0]            wr_sel,
  output logic [NUM_READ-1:0]                        bypass,
  output logic                                       r0_write_drop
);

  localparam int NREG = onehot_width(ADDR_W);

  // Write qualification: a protected r0 write is converted into a drop pulse.
  logic wr_is_r0;
  logic r0_drop_d;
  logic we_eff;

  assign wr_is_r0  = (wr_addr == ADDR_W'(R0_ADDR));
  assign r0_drop_d = wr_en & PROTECT_R0 & wr_is_r0;
  assign we_eff    = wr_en & ~(PROTECT_R0 & wr_is_r0);

  // Decoders 0..NUM_READ-1 serve the read ports, decoder NUM_READ the write port.
  logic [NUM_READ*NREG-1:0] rd_sel_d;
  logic [NREG-1:0]          wr_sel_d;

  for (genvar p = 0; p <= NUM_READ; p++) begin : g_dec
    if (p < NUM_READ) begin : g_rd
      onehot_decoder #(.ADDR_W(ADDR_W)) u_dec (
        .en_i   (1'b1),
        .addr_i (rd_addr[p*ADDR_W +: ADDR_W]),
        .sel_o  (rd_sel_d[p*NREG +: NREG])
      );
    end else begin : g_wr
      onehot_decoder #(.ADDR_W(ADDR_W)) u_dec (
        .en_i   (we_eff),
        .addr_i (wr_addr),
        .sel_o  (wr_sel_d)
      );
    end
  end

  // Same-register collision per read port; duplicates each flag independently.
  logic [NUM_READ-1:0] bypass_d;

  always_comb begin
    bypass_d = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      bypass_d[p] = we_eff & (rd_addr[p*ADDR_W +: ADDR_W] == wr_addr);
    end
  end

  // Pipeline registers. A bubble zeroes the payload rather than holding it.
  logic                     out_valid_q;
  logic [NUM_READ*NREG-1:0] rd_sel_q;
  logic [NREG-1:0]          wr_sel_q;
  logic [NUM_READ-1:0]      bypass_q;
  logic                     r0_drop_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      rd_sel_q    <= '0;
      wr_sel_q    <= '0;
      bypass_q    <= '0;
      r0_drop_q   <= 1'b0;
    end else if (!stall) begin
      if (in_valid) begin
        out_valid_q <= 1'b1;
        rd_sel_q    <= rd_sel_d;
        wr_sel_q    <= wr_sel_d;
        bypass_q    <= bypass_d;
        r0_drop_q   <= r0_drop_d;
      end else begin
        out_valid_q <= 1'b0;
        rd_sel_q    <= '0;
        wr_sel_q    <= '0;
        bypass_q    <= '0;
        r0_drop_q   <= 1'b0;
      end
    end
  end

  assign in_ready      = ~stall;
  assign out_valid     = out_valid_q;
  assign rd_sel        = rd_sel_q;
  assign wr_sel        = wr_sel_q;
  assign bypass        = bypass_q;
  assign r0_write_drop = r0_drop_q;

endmodule

// File: tb/tb_regfile_port_decoder.sv
// Scoreboard bench for regfile_port_decoder across three configurations.
// Latency: expectations are queued one per clock edge and popped one cycle later.
// Backpressure: stall and bubble cycles are driven at random and from directed cases.
module tb_regfile_port_decoder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, in_valid, stall;

  // Side A: default geometry, shared by the protected and unprotected instances.
  logic [9:0] rd_addr_a;
  logic [4:0] wr_addr_a;
  logic       wr_en_a;
  // Side B: ADDR_W=3, NUM_READ=3.
  logic [8:0] rd_addr_b;
  logic [2:0] wr_addr_b;
  logic       wr_en_b;

  logic        in_ready0, out_valid0, drop0;
  logic [63:0] rd_sel0;
  logic [31:0] wr_sel0;
  logic [1:0]  bypass0;

  logic        in_ready1, out_valid1, drop1;
  logic [63:0] rd_sel1;
  logic [31:0] wr_sel1;
  logic [1:0]  bypass1;

  logic        in_ready2, out_valid2, drop2;
  logic [23:0] rd_sel2;
  logic [7:0]  wr_sel2;
  logic [2:0]  bypass2;

  regfile_port_decoder #(.ADDR_W(5), .NUM_READ(2), .PROTECT_R0(1'b1)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .stall(stall),
    .rd_addr(rd_addr_a), .wr_addr(wr_addr_a), .wr_en(wr_en_a),
    .in_ready(in_ready0), .out_valid(out_valid0), .rd_sel(rd_sel0),
    .wr_sel(wr_sel0), .bypass(bypass0), .r0_write_drop(drop0)
  );

  regfile_port_decoder #(.ADDR_W(5), .NUM_READ(2), .PROTECT_R0(1'b0)) dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .stall(stall),
    .rd_addr(rd_addr_a), .wr_addr(wr_addr_a), .wr_en(wr_en_a),
    .in_ready(in_ready1), .out_valid(out_valid1), .rd_sel(rd_sel1),
    .wr_sel(wr_sel1), .bypass(bypass1), .r0_write_drop(drop1)
  );

  regfile_port_decoder #(.ADDR_W(3), .NUM_READ(3), .PROTECT_R0(1'b1)) dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .stall(stall),
    .rd_addr(rd_addr_b), .wr_addr(wr_addr_b), .wr_en(wr_en_b),
    .in_ready(in_ready2), .out_valid(out_valid2), .rd_sel(rd_sel2),
    .wr_sel(wr_sel2), .bypass(bypass2), .r0_write_drop(drop2)
  );

  typedef struct packed {
    logic         ov;
    logic [127:0] rd;
    logic [31:0]  wr;
    logic [3:0]   byp;
    logic         drop;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  exp_t p0, p1, p2;
  int   checks = 0;
  int   errors = 0;
  bit   started = 0;
  int   bidx = 0;

  // Reference: what the outputs must show after the next edge, from the
  // capture rules (reset > stall > valid/bubble) and plain 1<<addr arithmetic.
  function automatic exp_t model(input exp_t prev, input bit rst_n, input bit iv,
                                 input bit st, input int aw, input int nr,
                                 input bit prot, input int ra[4], input int wa,
                                 input bit we);
    exp_t e;
    int   nreg;
    bit   r0w;
    bit   weff;
    e    = '0;
    nreg = 1 << aw;
    if (!rst_n) return e;
    if (st) return prev;
    if (!iv) return e;
    r0w    = prot && (wa == 0);
    weff   = we && !r0w;
    e.ov   = 1'b1;
    e.drop = we && r0w;
    for (int p = 0; p < nr; p++) begin
      e.rd[p*nreg + ra[p]] = 1'b1;
      if (weff && ra[p] == wa) e.byp[p] = 1'b1;
    end
    if (weff) e.wr[wa] = 1'b1;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk(input string dn, input exp_t e, input exp_t a);
    cmp({dn, ".out_valid"},     128'(a.ov),   128'(e.ov));
    cmp({dn, ".rd_sel"},        a.rd,         e.rd);
    cmp({dn, ".wr_sel"},        128'(a.wr),   128'(e.wr));
    cmp({dn, ".bypass"},        128'(a.byp),  128'(e.byp));
    cmp({dn, ".r0_write_drop"}, 128'(a.drop), 128'(e.drop));
  endtask

  // Monitor: every edge produces exactly one expected entry per instance.
  always @(posedge clock) begin
    #1;
    if (started) begin
      if (q0.size() == 0 || q1.size() == 0 || q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: got empty queue expected entry at %0t", $time);
      end else begin
        chk("dut0", q0.pop_front(),
            '{ov: out_valid0, rd: 128'(rd_sel0), wr: 32'(wr_sel0), byp: 4'(bypass0), drop: drop0});
        chk("dut1", q1.pop_front(),
            '{ov: out_valid1, rd: 128'(rd_sel1), wr: 32'(wr_sel1), byp: 4'(bypass1), drop: drop1});
        chk("dut2", q2.pop_front(),
            '{ov: out_valid2, rd: 128'(rd_sel2), wr: 32'(wr_sel2), byp: 4'(bypass2), drop: drop2});
      end
    end
  end

  // Drive one input set and queue what the following edge must produce.
  task automatic apply(input bit rst_n, input bit iv, input bit st,
                       input int a1, input int a0, input int wa, input bit we);
    int ra[4];
    int rb[4];
    int wb;
    bit web;
    ra = '{a0, a1, 0, 0};
    for (int p = 0; p < 4; p++) rb[p] = (bidx + 3 * p) % 8;
    wb  = $urandom_range(0, 7);
    web = 1'($urandom_range(0, 1));
    bidx++;

    reset     = rst_n;
    in_valid  = iv;
    stall     = st;
    rd_addr_a = {5'(a1), 5'(a0)};
    wr_addr_a = 5'(wa);
    wr_en_a   = we;
    rd_addr_b = {3'(rb[2]), 3'(rb[1]), 3'(rb[0])};
    wr_addr_b = 3'(wb);
    wr_en_b   = web;

    p0 = model(p0, rst_n, iv, st, 5, 2, 1'b1, ra, wa, we);
    p1 = model(p1, rst_n, iv, st, 5, 2, 1'b0, ra, wa, we);
    p2 = model(p2, rst_n, iv, st, 3, 3, 1'b1, rb, wb, web);
    q0.push_back(p0);
    q1.push_back(p1);
    q2.push_back(p2);

    #1;
    cmp("dut0.in_ready", 128'(in_ready0), 128'(!st));
    cmp("dut1.in_ready", 128'(in_ready1), 128'(!st));
    cmp("dut2.in_ready", 128'(in_ready2), 128'(!st));
  endtask

  task automatic step(input bit rst_n, input bit iv, input bit st,
                      input int a1, input int a0, input int wa, input bit we);
    @(negedge clock);
    apply(rst_n, iv, st, a1, a0, wa, we);
  endtask

  initial begin
    int a0, a1, wa;
    p0 = '0;
    p1 = '0;
    p2 = '0;
    started = 1;

    // Reset held with a valid set on the inputs, then released.
    apply(0, 1, 0, 7, 3, 0, 0);
    step (0, 1, 1, 7, 3, 0, 0);
    step (1, 1, 0, 7, 3, 0, 0);
    // Basic decode, bypass with duplicate reads, r0 write.
    step (1, 1, 0, 31, 1, 5, 1);
    step (1, 1, 0, 9, 9, 9, 1);
    step (1, 1, 0, 0, 0, 0, 1);
    // Capture A, stall three cycles with changing inputs, then a bubble.
    step (1, 1, 0, 4, 2, 2, 1);
    for (int i = 0; i < 3; i++)
      step(1, 1'($urandom_range(0, 1)), 1, $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom_range(0, 1)));
    step (1, 0, 0, 12, 13, 14, 1);
    step (1, 0, 0, 12, 13, 14, 1);

    // Randomised traffic with collisions, r0 writes, stalls, bubbles and resets.
    for (int i = 0; i < 400; i++) begin
      wa = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 31);
      a0 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 31);
      a1 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 31);
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 4) == 0), a1, a0, wa, 1'($urandom_range(0, 1)));
    end

    // Drain the last expectation with a bounded wait.
    for (int i = 0; i < 10; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
      @(posedge clock);
      #2;
    end
    started = 0;
    checks++;
    if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left expected 0", q0.size() + q1.size() + q2.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
